// File: rtl/fifo_pkg.sv
// Shared constants, read-FSM states and gray-code helpers for the dual-clock 64x32 SRAM FIFO.
package fifo_pkg;

  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 6;
  localparam int FRAME_LEN = 256;
  localparam int CNT_W     = 9;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } rd_state_t;

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] gray);
    logic [ADDR_W:0] bin;
    bin[ADDR_W] = gray[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry valid/ready skid buffer holding words read from the SRAM until the consumer takes them.
module rd_skid_buf #(
  parameter int W = 32
) (
  input  logic         rclk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   occ_q;
  logic         pop;

  assign pop     = (occ_q != 2'd0) && ready_i;
  assign valid_o = (occ_q != 2'd0);
  assign data_o  = head_q;
  assign occ_o   = occ_q;

  // The head only changes on a pop, so a stalled word stays put on data_o.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push_i, pop})
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data_i;
          end else begin
            head_q <= push_data_i;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= push_data_i;
            occ_q  <= 2'd1;
          end else if (occ_q == 2'd1) begin
            tail_q <= push_data_i;
            occ_q  <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock SRAM FIFO: read pointer, empty flag, SRAM read issue and framing.
module fifo_rd_ctrl
  import fifo_pkg::*;
(
  input  logic              rclk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wptr_sync_i,
  output logic [ADDR_W:0]   rptr_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [WIDTH-1:0]  ram_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic              rempty_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  word_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);

  rd_state_t        state_q;
  logic [ADDR_W:0]  rbin_q;
  logic [ADDR_W:0]  rbin_d;
  logic [ADDR_W:0]  rptr_q;
  logic             rempty_q;
  logic             inflight_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [1:0]       skid_occ;
  logic             issue;
  logic             accept;

  rd_skid_buf #(
    .W(WIDTH)
  ) u_skid (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i(ram_rdata_i),
    .ready_i    (out_ready_i),
    .valid_o    (out_valid_o),
    .data_o     (out_data_o),
    .occ_o      (skid_occ)
  );

  assign accept = out_valid_o & out_ready_i;

  // Only read when the skid is guaranteed room for the word, counting the one still coming out of the SRAM.
  always_comb begin
    issue  = !rempty_q && (state_q == STREAM) &&
             (({1'b0, skid_occ} + {2'b00, inflight_q}) < 3'd2);
    rbin_d = rbin_q + {{ADDR_W{1'b0}}, issue};
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= bin2gray(rbin_d);
      rempty_q   <= (bin2gray(rbin_d) == wptr_sync_i);
      inflight_q <= issue;
    end
  end

  // Issue stops at the frame's last word; the next frame waits in the SRAM until DONE.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      issued_q     <= '0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        word_cnt_q <= (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!rempty_q) state_q <= STREAM;
        end
        STREAM: begin
          if (issue) begin
            issued_q <= issued_q + 1'b1;
            if (issued_q == LAST_WORD) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept && (word_cnt_q == LAST_WORD)) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          issued_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rptr_o       = rptr_q;
  assign ram_raddr_o  = rbin_q[ADDR_W-1:0];
  assign rempty_o     = rempty_q;
  assign frame_done_o = frame_done_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: cycle-exact vector table for reset and first words, then randomized traffic vs a queue model.
module tb_fifo_rd_ctrl;

  localparam int FRAME = 256;

  typedef struct {
    logic        rstN;
    logic [6:0]  wbin;
    logic        ready;
    logic        expValid;
    logic        expEmpty;
    logic [6:0]  expRptrBin;
    logic [5:0]  expRaddr;
    logic [8:0]  expCnt;
    logic        expDone;
    logic        checkData;
    logic [31:0] expData;
  } vec_t;

  logic        rclk = 1'b0;
  logic        rstN;
  logic [6:0]  wptrSync;
  logic [6:0]  rptr;
  logic [5:0]  ramRaddr;
  logic [31:0] ramRdata;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic        rempty;
  logic        frameDone;
  logic [8:0]  wordCnt;

  logic [31:0] mem [64];
  logic [31:0] expQ [$];
  vec_t        vecs [$];

  int checks = 0;
  int errors = 0;
  int written, accepted, issued, framesDone;
  logic       expectDone;
  logic [6:0] prevRptr;
  logic [5:0] prevRaddr;

  fifo_rd_ctrl dut (
    .rclk        (rclk),
    .rst_n       (rstN),
    .wptr_sync_i (wptrSync),
    .rptr_o      (rptr),
    .ram_raddr_o (ramRaddr),
    .ram_rdata_i (ramRdata),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (outData),
    .rempty_o    (rempty),
    .frame_done_o(frameDone),
    .word_cnt_o  (wordCnt)
  );

  always #5 rclk = ~rclk;

  // SRAM port B: registered read, data valid one rclk after the address.
  always @(posedge rclk) ramRdata <= mem[ramRaddr];

  function automatic logic [6:0] toGray(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [6:0] fromGray(input logic [6:0] g);
    logic [6:0] b;
    b[6] = g[6];
    for (int i = 5; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic vec_t mkVec(input logic r, input logic [6:0] w, input logic rdy,
                                 input logic v, input logic e, input logic [6:0] rp,
                                 input logic [5:0] a, input logic [8:0] c, input logic d,
                                 input logic cd, input logic [31:0] dat);
    vec_t t;
    t.rstN = r; t.wbin = w; t.ready = rdy;
    t.expValid = v; t.expEmpty = e; t.expRptrBin = rp; t.expRaddr = a;
    t.expCnt = c; t.expDone = d; t.checkData = cd; t.expData = dat;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    rstN     = v.rstN;
    wptrSync = toGray(v.wbin);
    outReady = v.ready;
    @(posedge rclk);
    #1;
    checkOutput($sformatf("row%0d out_valid", idx), 32'(outValid), 32'(v.expValid));
    checkOutput($sformatf("row%0d rempty", idx), 32'(rempty), 32'(v.expEmpty));
    checkOutput($sformatf("row%0d rptr", idx), 32'(rptr), 32'(toGray(v.expRptrBin)));
    checkOutput($sformatf("row%0d ram_raddr", idx), 32'(ramRaddr), 32'(v.expRaddr));
    checkOutput($sformatf("row%0d word_cnt", idx), 32'(wordCnt), 32'(v.expCnt));
    checkOutput($sformatf("row%0d frame_done", idx), 32'(frameDone), 32'(v.expDone));
    if (v.checkData) checkOutput($sformatf("row%0d out_data", idx), outData, v.expData);
  endtask

  // One rclk of traffic: the accept is judged against the outputs seen before the edge, everything else after it.
  task automatic stepCycle(input logic readyVal, input logic doWrite);
    logic        hold;
    logic [31:0] heldData;
    logic [31:0] expWord;
    logic [31:0] word;
    logic [6:0]  curRptr;
    logic [6:0]  rbinSeen;
    logic [5:0]  nextAddr;
    outReady = readyVal;
    hold     = outValid && !readyVal;
    heldData = outData;
    if (outValid && readyVal) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL spurious word: got %0h, expected no word", outData);
      end else begin
        expWord = expQ.pop_front();
        if (outData !== expWord) begin
          errors++;
          $display("[TB] FAIL data order: got %0h, expected %0h", outData, expWord);
        end
      end
      accepted++;
      if (accepted % FRAME == 0) expectDone = 1'b1;
    end
    if (doWrite && (written - accepted) < 64) begin
      word = $urandom;
      mem[written % 64] = word;
      expQ.push_back(word);
      written++;
    end
    wptrSync = toGray(7'(written));
    @(posedge rclk);
    #1;
    checkOutput("frame_done", 32'(frameDone), 32'(expectDone));
    if (expectDone) framesDone++;
    expectDone = 1'b0;
    checkOutput("word_cnt", 32'(wordCnt), 32'(accepted % FRAME));
    if (hold) begin
      checkOutput("held valid", 32'(outValid), 32'd1);
      checkOutput("held data", outData, heldData);
    end
    curRptr = rptr;
    if (curRptr != prevRptr) begin
      nextAddr = prevRaddr + 6'd1;
      checkOutput("rptr one-bit step", 32'($countones(curRptr ^ prevRptr)), 32'd1);
      checkOutput("raddr sequence", 32'(ramRaddr), 32'(nextAddr));
      issued++;
    end
    rbinSeen = fromGray(curRptr);
    checkOutput("raddr matches rptr", 32'(ramRaddr), 32'(rbinSeen[5:0]));
    checkOutput("rptr count", 32'(rbinSeen), 32'(issued % 128));
    checkOutput("pending <= 2", 32'((issued - accepted) <= 2), 32'd1);
    checkOutput("no read past write", 32'(issued <= written), 32'd1);
    checkOutput("frame boundary", 32'(issued <= FRAME * (framesDone + 1)), 32'd1);
    checkOutput("rempty", 32'(rempty), 32'(issued == written));
    prevRptr  = curRptr;
    prevRaddr = ramRaddr;
  endtask

  task automatic resetModel(input int startCount);
    written    = startCount;
    accepted   = startCount;
    issued     = startCount;
    framesDone = 0;
    expectDone = 1'b0;
    expQ.delete();
    prevRptr   = toGray(7'(startCount));
    prevRaddr  = 6'(startCount);
  endtask

  initial begin
    int budget;
    rstN     = 1'b0;
    wptrSync = '0;
    outReady = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + 32'(i);

    // rst, wbin, ready | valid, empty, rptrBin, raddr, cnt, done, checkData, data
    vecs.push_back(mkVec(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 32'h0));
    for (int i = 0; i < 10; i++) vecs.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mkVec(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mkVec(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mkVec(1, 4, 1, 0, 0, 1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mkVec(1, 4, 1, 1, 0, 2, 2, 0, 0, 1, 32'hA000_0000));
    vecs.push_back(mkVec(1, 4, 1, 1, 0, 2, 2, 1, 0, 1, 32'hA000_0001));
    vecs.push_back(mkVec(1, 4, 1, 0, 0, 3, 3, 2, 0, 0, 32'h0));
    vecs.push_back(mkVec(1, 4, 1, 1, 1, 4, 4, 2, 0, 1, 32'hA000_0002));
    vecs.push_back(mkVec(1, 4, 1, 1, 1, 4, 4, 3, 0, 1, 32'hA000_0003));
    vecs.push_back(mkVec(1, 4, 1, 0, 1, 4, 4, 4, 0, 0, 32'h0));
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // Randomized traffic through a frame boundary, with a backpressure window early on.
    resetModel(4);
    budget = 0;
    while (accepted < 300 && budget < 4000) begin
      stepCycle((budget >= 3 && budget <= 10) ? 1'b0 : ($urandom_range(3) != 0),
                (written < 300) && ($urandom_range(3) != 0));
      budget++;
    end
    checkOutput("first run drained", 32'(accepted), 32'd300);
    checkOutput("one frame done", 32'(framesDone), 32'd1);

    // Fill the skid at word_cnt=100 of the second frame, then reset asynchronously.
    budget = 0;
    while (accepted < 356 && budget < 1000) begin
      stepCycle(1'b1, written < 380);
      budget++;
    end
    for (int i = 0; i < 6; i++) stepCycle(1'b0, 1'b0);
    checkOutput("pre-reset word_cnt", 32'(wordCnt), 32'd100);
    checkOutput("pre-reset skid full", 32'(issued - accepted), 32'd2);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async rst rptr", 32'(rptr), 32'd0);
    checkOutput("async rst raddr", 32'(ramRaddr), 32'd0);
    checkOutput("async rst valid", 32'(outValid), 32'd0);
    checkOutput("async rst data", outData, 32'd0);
    checkOutput("async rst rempty", 32'(rempty), 32'd1);
    checkOutput("async rst word_cnt", 32'(wordCnt), 32'd0);
    checkOutput("async rst frame_done", 32'(frameDone), 32'd0);
    wptrSync = '0;
    @(negedge rclk);
    @(negedge rclk);
    rstN = 1'b1;
    @(posedge rclk);
    #1;

    // After release the reader must sit idle until new words appear.
    resetModel(0);
    for (int i = 0; i < 8; i++) stepCycle(1'b1, 1'b0);
    checkOutput("idle after reset valid", 32'(outValid), 32'd0);
    budget = 0;
    while ((accepted < 20 || written < 20) && budget < 500) begin
      stepCycle($urandom_range(3) != 0, written < 20);
      budget++;
    end
    checkOutput("post-reset drained", 32'(accepted), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
